// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//
// Walks register indices FIRST_REG..LAST_REG of a 32x32 register file and
// either dumps them onto an output stream (mode=0) or loads them from an input
// stream (mode=1).
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   start, mode     sequence request, sampled only while idle
//   busy, done      busy outside IDLE; done is a one-cycle completion pulse
//   rdReg, rdData   regfile read port (rdData is combinational from rdReg)
//   wrEnable, wrReg, wrData   regfile write port
//   outValid, outData, outIdx, outReady   dump stream (registered source)
//   inValid, inData, inReady              load stream
//   dbgState        current FSM state, for observation only
//
// Handshake: a beat moves on any rising edge where valid && ready are both 1.
// The source holds valid, data and index stable until that edge; ready may
// be driven freely and never depends on valid in the same cycle.
// -----------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rdReg,
    input  logic [31:0] rdData,
    output logic        wrEnable,
    output logic [4:0]  wrReg,
    output logic [31:0] wrData,
    output logic        outValid,
    output logic [31:0] outData,
    output logic [4:0]  outIdx,
    input  logic        outReady,
    input  logic        inValid,
    input  logic [31:0] inData,
    output logic        inReady,
    output logic [2:0]  dbgState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DUMP  = 3'd1,
        DRAIN = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } stateT;

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    stateT       stateQ, stateNext;
    logic [4:0]  idxQ, idxNext;
    logic        outValidQ, outValidNext;
    logic [31:0] outDataQ, outDataNext;
    logic [4:0]  outIdxQ, outIdxNext;
    logic        slotFree;

    // The output register can take a new beat when it is empty or its
    // current beat is being accepted at this edge.
    assign slotFree = !outValidQ || outReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            idxQ      <= FIRST_IDX;
            outValidQ <= 1'b0;
            outDataQ  <= 32'd0;
            outIdxQ   <= 5'd0;
        end else begin
            stateQ    <= stateNext;
            idxQ      <= idxNext;
            outValidQ <= outValidNext;
            outDataQ  <= outDataNext;
            outIdxQ   <= outIdxNext;
        end
    end

    always_comb begin
        stateNext    = stateQ;
        idxNext      = idxQ;
        outValidNext = outValidQ;
        outDataNext  = outDataQ;
        outIdxNext   = outIdxQ;
        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    idxNext   = FIRST_IDX;
                    stateNext = mode ? LOAD : DUMP;
                end
            end
            DUMP: begin
                if (slotFree) begin
                    outDataNext  = rdData;
                    outIdxNext   = idxQ;
                    outValidNext = 1'b1;
                    // idx stops at LAST_REG; the last beat drains from DRAIN.
                    if (idxQ == LAST_IDX) stateNext = DRAIN;
                    else                  idxNext   = idxQ + 5'd1;
                end
            end
            DRAIN: begin
                if (outReady) begin
                    outValidNext = 1'b0;
                    stateNext    = DONE;
                end
            end
            LOAD: begin
                if (inValid) begin
                    if (idxQ == LAST_IDX) stateNext = DONE;
                    else                  idxNext   = idxQ + 5'd1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy     = (stateQ != IDLE);
    assign done     = (stateQ == DONE);
    assign rdReg    = idxQ;
    assign wrReg    = idxQ;
    assign wrData   = inData;
    assign inReady  = (stateQ == LOAD);
    // Reset wins over an accepted load beat: nothing is written that cycle.
    assign wrEnable = (stateQ == LOAD) && inValid && !rst;
    assign outValid = outValidQ;
    assign outData  = outDataQ;
    assign outIdx   = outIdxQ;
    assign dbgState = stateQ;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // ---------------- DUT A: full range 0..31 ----------------
  logic        rstA, startA, modeA, busyA, doneA, wrEnableA;
  logic        outValidA, outReadyA, inValidA, inReadyA;
  logic [4:0]  rdRegA, wrRegA, outIdxA;
  logic [31:0] rdDataA, wrDataA, outDataA, inDataA;
  logic [2:0]  dbgStateA;

  regfile_sequencer #(.FIRST_REG(0), .LAST_REG(31)) dutA (
    .clk(clk), .rst(rstA), .start(startA), .mode(modeA),
    .busy(busyA), .done(doneA), .rdReg(rdRegA), .rdData(rdDataA),
    .wrEnable(wrEnableA), .wrReg(wrRegA), .wrData(wrDataA),
    .outValid(outValidA), .outData(outDataA), .outIdx(outIdxA), .outReady(outReadyA),
    .inValid(inValidA), .inData(inDataA), .inReady(inReadyA), .dbgState(dbgStateA)
  );

  // ---------------- DUT B: window 4..6 ----------------
  logic        rstB, startB, modeB, busyB, doneB, wrEnableB;
  logic        outValidB, outReadyB, inValidB, inReadyB;
  logic [4:0]  rdRegB, wrRegB, outIdxB;
  logic [31:0] rdDataB, wrDataB, outDataB, inDataB;
  logic [2:0]  dbgStateB;

  regfile_sequencer #(.FIRST_REG(4), .LAST_REG(6)) dutB (
    .clk(clk), .rst(rstB), .start(startB), .mode(modeB),
    .busy(busyB), .done(doneB), .rdReg(rdRegB), .rdData(rdDataB),
    .wrEnable(wrEnableB), .wrReg(wrRegB), .wrData(wrDataB),
    .outValid(outValidB), .outData(outDataB), .outIdx(outIdxB), .outReady(outReadyB),
    .inValid(inValidB), .inData(inDataB), .inReady(inReadyB), .dbgState(dbgStateB)
  );

  // ---------------- register files (environment) ----------------
  logic [31:0] regsA[32], preA[32], regsB[32], preB[32];
  logic        preloadA = 1'b0, preloadB = 1'b0;
  logic [31:0] expRegs[32];
  logic [31:0] expRegsB[32];

  assign rdDataA = regsA[rdRegA];
  assign rdDataB = regsB[rdRegB];

  always @(posedge clk) begin
    if (preloadA) regsA <= preA;
    else if (wrEnableA) regsA[wrRegA] <= wrDataA;
  end

  always @(posedge clk) begin
    if (preloadB) regsB <= preB;
    else if (wrEnableB) regsB[wrRegB] <= wrDataB;
  end

  // ---------------- checking ----------------
  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // kind 0: regfile[i] = i*2, kind 1: random contents
  task automatic setRegsA(input int kind);
    for (int i = 0; i < 32; i++) begin
      preA[i] = (kind == 0) ? 32'(i * 2) : $urandom;
      expRegs[i] = preA[i];
    end
    @(negedge clk); preloadA = 1'b1;
    @(negedge clk); preloadA = 1'b0;
  endtask

  // readyPat 0: always ready, 1: alternating, 2: random
  task automatic doDump(input int readyPat, input bit pokeStart);
    logic [36:0] expQ[$];
    int beats = 0;
    int doneCnt = 0;
    int wrCnt = 0;
    int lastCyc = 0;
    bit ended = 0;
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), expRegs[i]});
    @(negedge clk); startA = 1'b1; modeA = 1'b0; outReadyA = 1'b0;
    @(negedge clk); startA = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cyc > 1) @(negedge clk);
      case (readyPat)
        0: outReadyA = 1'b1;
        1: outReadyA = (cyc % 2 == 0);
        default: outReadyA = 1'($urandom_range(0, 1));
      endcase
      // a start request mid-dump, asking for a load, must be ignored
      startA = pokeStart && (beats == 5);
      modeA = pokeStart;
      #1;
      lastCyc = cyc;
      if (!busyA) begin
        ended = 1;
        break;
      end
      checkEq("dump_done", doneA, expQ.size() == 0);
      if (doneA) doneCnt++;
      if (wrEnableA || inReadyA) wrCnt++;
      if (expQ.size() == 0) begin
        checkEq("dump_valid_off", outValidA, 0);
      end else begin
        checkEq("dump_valid", outValidA, cyc >= 2);
        if (outValidA) begin
          checkEq("dump_idx", outIdxA, expQ[0][36:32]);
          checkEq("dump_data", outDataA, expQ[0][31:0]);
          if (outReadyA) begin
            void'(expQ.pop_front());
            beats++;
          end
        end
      end
    end
    startA = 1'b0;
    modeA = 1'b0;
    outReadyA = 1'b0;
    checkEq("dump_ended", ended, 1);
    checkEq("dump_beats", beats, 32);
    checkEq("dump_done_pulses", doneCnt, 1);
    checkEq("dump_no_writes", wrCnt, 0);
    if (readyPat == 0) checkEq("dump_cycles", lastCyc, 35);
  endtask

  // gapMode 0: inValid always, 1: gap every third cycle, 2: random gaps
  task automatic doLoad(input int gapMode, input bit randData, input int rstAt);
    logic [31:0] vals[32];
    int wr = 0;
    int doneCnt = 0;
    bit ended = 0;
    bit doRst;
    for (int i = 0; i < 32; i++) vals[i] = randData ? $urandom : 32'(100 + i);
    @(negedge clk); startA = 1'b1; modeA = 1'b1;
    @(negedge clk); startA = 1'b0; modeA = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cyc > 1) @(negedge clk);
      case (gapMode)
        0: inValidA = 1'b1;
        1: inValidA = (cyc % 3 != 0);
        default: inValidA = ($urandom_range(0, 3) != 0);
      endcase
      inDataA = (wr < 32) ? vals[wr] : $urandom;
      doRst = (rstAt >= 0) && (wr == rstAt) && inValidA;
      rstA = doRst;
      #1;
      if (!busyA) begin
        ended = 1;
        break;
      end
      checkEq("load_ready", inReadyA, wr < 32);
      checkEq("load_done", doneA, wr == 32);
      checkEq("load_wen", wrEnableA, inValidA && (wr < 32) && !doRst);
      checkEq("load_outvalid", outValidA, 0);
      if (doneA) doneCnt++;
      if (wrEnableA) begin
        checkEq("load_reg", wrRegA, wr);
        checkEq("load_data", wrDataA, vals[wr]);
        expRegs[wr] = vals[wr];
        wr++;
      end
      if (doRst) begin
        @(negedge clk);
        rstA = 1'b0;
        inValidA = 1'b0;
        #1;
        checkEq("rst_busy", busyA, 0);
        checkEq("rst_done", doneA, 0);
        checkEq("rst_idx", rdRegA, 0);
        checkEq("rst_wen", wrEnableA, 0);
        ended = 1;
        break;
      end
    end
    inValidA = 1'b0;
    rstA = 1'b0;
    checkEq("load_ended", ended, 1);
    checkEq("load_writes", wr, (rstAt < 0) ? 32 : rstAt);
    if (rstAt < 0) begin
      checkEq("load_done_pulses", doneCnt, 1);
      checkEq("load_ready_after", inReadyA, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) checkEq("regfile", regsA[i], expRegs[i]);
  endtask

  task automatic doDumpB();
    logic [36:0] expQ[$];
    int beats = 0;
    int doneCnt = 0;
    bit ended = 0;
    for (int i = 0; i < 32; i++) begin
      preB[i] = $urandom;
      expRegsB[i] = preB[i];
    end
    @(negedge clk); preloadB = 1'b1;
    @(negedge clk); preloadB = 1'b0;
    for (int i = 4; i <= 6; i++) expQ.push_back({5'(i), expRegsB[i]});
    @(negedge clk); startB = 1'b1; modeB = 1'b0;
    @(negedge clk); startB = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (cyc > 1) @(negedge clk);
      outReadyB = 1'($urandom_range(0, 1));
      #1;
      if (!busyB) begin
        ended = 1;
        break;
      end
      checkEq("win_done", doneB, expQ.size() == 0);
      if (doneB) doneCnt++;
      if (expQ.size() == 0) begin
        checkEq("win_valid_off", outValidB, 0);
      end else begin
        checkEq("win_valid", outValidB, cyc >= 2);
        if (outValidB) begin
          checkEq("win_idx", outIdxB, expQ[0][36:32]);
          checkEq("win_data", outDataB, expQ[0][31:0]);
          if (outReadyB) begin
            void'(expQ.pop_front());
            beats++;
          end
        end
      end
    end
    outReadyB = 1'b0;
    checkEq("win_ended", ended, 1);
    checkEq("win_beats", beats, 3);
    checkEq("win_done_pulses", doneCnt, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstA = 1'b1; startA = 1'b0; modeA = 1'b0; outReadyA = 1'b0; inValidA = 1'b0; inDataA = '0;
    rstB = 1'b1; startB = 1'b0; modeB = 1'b0; outReadyB = 1'b0; inValidB = 1'b0; inDataB = '0;
    repeat (3) @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;
    #1;
    checkEq("reset_busy", busyA, 0);
    checkEq("reset_done", doneA, 0);
    checkEq("reset_outvalid", outValidA, 0);
    checkEq("reset_outdata", outDataA, 0);
    checkEq("reset_outidx", outIdxA, 0);
    checkEq("reset_idx", rdRegA, 0);
    checkEq("reset_inready", inReadyA, 0);
    checkEq("reset_wen", wrEnableA, 0);
    checkEq("reset_idx_win", rdRegB, 4);
    checkEq("reset_busy_win", busyB, 0);

    setRegsA(0);
    doDump(0, 0);
    doDump(1, 0);
    doDump(0, 1);
    setRegsA(1);
    doDump(2, 0);
    doLoad(1, 0, -1);
    doDump(2, 0);
    doLoad(2, 1, 10);
    doLoad(2, 1, -1);
    doDump(1, 1);
    doDumpB();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
